// File: rtl/oam_dma_master_pkg.sv
// rtl/oam_dma_master_pkg.sv - shared constants and state type for the OAM DMA master
package oam_dma_master_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
    localparam logic [15:0] OAM_BASE_DEFAULT     = 16'hFE00;
    localparam int          OAM_BYTES_DEFAULT    = 160;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        CAP,
        WR,
        DONE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_master_reg_if.sv
// rtl/oam_dma_master_reg_if.sv - DMA register decode, source-page register and readback
import oam_dma_master_pkg::*;

module oam_dma_master_reg_if #(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [7:0]  reg_wdata,
    input  logic        load,
    output logic        wr_hit,
    output logic [7:0]  src_hi,
    output logic [7:0]  reg_rdata,
    output logic        reg_rdata_oe
);

    logic rd_hit;

    assign wr_hit = reg_wr && (reg_addr == DMA_REG_ADDR);
    assign rd_hit = reg_rd && (reg_addr == DMA_REG_ADDR);

    // Source page loads only when the master accepts the write; readback is registered one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_hi       <= 8'h00;
            reg_rdata    <= 8'h00;
            reg_rdata_oe <= 1'b0;
        end else begin
            if (load) begin
                src_hi <= reg_wdata;
            end
            reg_rdata_oe <= rd_hit;
            reg_rdata    <= rd_hit ? src_hi : 8'h00;
        end
    end

endmodule

// File: rtl/oam_dma_master.sv
// rtl/oam_dma_master.sv - OAM DMA bus initiator; OAM_DMA_RESTART_EN allows restart while busy
import oam_dma_master_pkg::*;

module oam_dma_master #(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter logic [15:0] OAM_BASE     = OAM_BASE_DEFAULT,
    parameter int          OAM_BYTES    = OAM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        reg_rdata_oe,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  bus_wdata,
    output logic        bus_wdata_oe,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [7:0] LAST_INDEX = 8'(OAM_BYTES - 1);

    dma_state_t state, state_next;
    logic [7:0] index, index_next;
    logic [7:0] data_latch;
    logic [7:0] src_hi;
    logic       wr_hit;
    logic       active;
    logic       start;
    logic       restart;
    logic       load;
    logic       latch_en;

    // DONE is not busy, so a write landing on the done pulse starts a fresh transfer
    assign active = (state == REQ) || (state == RD) || (state == CAP) || (state == WR);
    assign start  = wr_hit && !active;

`ifdef OAM_DMA_RESTART_EN
    assign restart = wr_hit && active;
`else
    assign restart = 1'b0;
`endif

    assign load = start || restart;

    oam_dma_master_reg_if #(
        .DMA_REG_ADDR(DMA_REG_ADDR)
    ) u_reg_if (
        .clk          (clk),
        .reset        (reset),
        .reg_addr     (reg_addr),
        .reg_wr       (reg_wr),
        .reg_rd       (reg_rd),
        .reg_wdata    (reg_wdata),
        .load         (load),
        .wr_hit       (wr_hit),
        .src_hi       (src_hi),
        .reg_rdata    (reg_rdata),
        .reg_rdata_oe (reg_rdata_oe)
    );

    // State, byte index and captured read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            index      <= 8'h00;
            data_latch <= 8'h00;
        end else begin
            state <= state_next;
            index <= index_next;
            if (latch_en) begin
                data_latch <= bus_rdata;
            end
        end
    end

    // Next state and bus outputs; strobes are gated by grant and the phase repeats until granted
    always_comb begin
        state_next   = state;
        index_next   = index;
        bus_req      = 1'b0;
        dma_busy     = 1'b0;
        bus_addr     = 16'h0000;
        bus_rd       = 1'b0;
        bus_wr       = 1'b0;
        bus_wdata    = 8'h00;
        bus_wdata_oe = 1'b0;
        dma_done     = 1'b0;
        latch_en     = 1'b0;
        case (state)
            IDLE: ;
            REQ: begin
                bus_req  = 1'b1;
                dma_busy = 1'b1;
                if (bus_grant) state_next = RD;
            end
            RD: begin
                bus_req  = 1'b1;
                dma_busy = 1'b1;
                bus_addr = {src_hi, index};
                bus_rd   = bus_grant;
                if (bus_grant) state_next = CAP;
            end
            CAP: begin
                bus_req    = 1'b1;
                dma_busy   = 1'b1;
                latch_en   = 1'b1;
                state_next = WR;
            end
            WR: begin
                bus_req      = 1'b1;
                dma_busy     = 1'b1;
                bus_addr     = OAM_BASE + {8'h00, index};
                bus_wr       = bus_grant;
                bus_wdata    = data_latch;
                bus_wdata_oe = bus_grant;
                if (bus_grant) begin
                    if (index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index + 8'd1;
                        state_next = RD;
                    end
                end
            end
            DONE: begin
                dma_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next = REQ;
            index_next = 8'h00;
        end
        if (restart) begin
            state_next = bus_grant ? RD : REQ;
            index_next = 8'h00;
        end
    end

endmodule

// File: tb/tb_oam_dma_master.sv
// tb/tb_oam_dma_master.sv - scoreboard bench for oam_dma_master (default and 256-byte instances)
module tb_oam_dma_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] reg_addr = 16'h0000;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [7:0]  reg_wdata = 8'h00;
    logic [7:0]  reg_rdata;
    logic        reg_rdata_oe;
    logic        bus_req;
    logic        bus_grant = 1'b1;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic        bus_wdata_oe;
    logic [7:0]  bus_rdata = 8'h00;
    logic        dma_busy;
    logic        dma_done;

    logic        reg_wr2 = 1'b0;
    logic        reg_rd2 = 1'b0;
    logic [7:0]  reg_rdata2;
    logic        reg_rdata_oe2;
    logic        bus_req2;
    logic [15:0] bus_addr2;
    logic        bus_rd2;
    logic        bus_wr2;
    logic [7:0]  bus_wdata2;
    logic        bus_wdata_oe2;
    logic [7:0]  bus_rdata2 = 8'h00;
    logic        dma_busy2;
    logic        dma_done2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_rd = -1;
    int done_cyc = -1;
    int done_count = 0;
    int start_cyc = 0;
    int r2 = 0;
    int w2 = 0;
    int done2 = 0;
    logic        seen_rd = 1'b0;
    logic [15:0] seen_rd_addr = 16'h0000;
    logic [15:0] exp_rd[$];
    logic [23:0] exp_wr[$];

    always #5 clk = ~clk;

    oam_dma_master u_dut (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rdata_oe(reg_rdata_oe),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_wdata_oe(bus_wdata_oe),
        .bus_rdata(bus_rdata), .dma_busy(dma_busy), .dma_done(dma_done)
    );

    oam_dma_master #(.OAM_BYTES(256)) u_dut256 (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_wr(reg_wr2), .reg_rd(reg_rd2),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata2), .reg_rdata_oe(reg_rdata_oe2),
        .bus_req(bus_req2), .bus_grant(1'b1), .bus_addr(bus_addr2), .bus_rd(bus_rd2),
        .bus_wr(bus_wr2), .bus_wdata(bus_wdata2), .bus_wdata_oe(bus_wdata_oe2),
        .bus_rdata(bus_rdata2), .dma_busy(dma_busy2), .dma_done(dma_done2)
    );

    // Responders: data returned the cycle after the read strobe is addr[7:0]^5A
    always @(posedge clk) begin
        if (bus_rd) bus_rdata <= bus_addr[7:0] ^ 8'h5A;
        if (bus_rd2) bus_rdata2 <= bus_addr2[7:0] ^ 8'h5A;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_transfer(input logic [7:0] src, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_rd.push_back({src, 8'(i)});
            exp_wr.push_back({16'hFE00 + 16'(i), 8'(i) ^ 8'h5A});
        end
    endtask

    // Sample mid-cycle, then return just after the next rising edge so callers drive inputs there
    task automatic step();
        logic [15:0] ea;
        logic [23:0] ew;
        @(negedge clk);
        cyc++;
        seen_rd      = bus_rd;
        seen_rd_addr = bus_addr;
        if (bus_rd || bus_wr) check("strobe_needs_grant", bus_grant, 1);
        if (bus_rd) begin
            if (first_rd < 0) first_rd = cyc;
            check("rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                ea = exp_rd.pop_front();
                check("rd_addr", bus_addr, ea);
            end
        end
        if (bus_wr) begin
            check("wr_expected", exp_wr.size() > 0, 1);
            check("wr_oe", bus_wdata_oe, 1);
            if (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                check("wr_addr_data", {bus_addr, bus_wdata}, ew);
            end
        end
        if (dma_done) begin
            done_count++;
            done_cyc = cyc;
            check("done_releases_req_busy", {bus_req, dma_busy}, 0);
        end
        if (bus_rd2) begin
            check("rd256_addr", bus_addr2, {8'hFF, 8'(r2)});
            r2++;
        end
        if (bus_wr2) begin
            check("wr256_addr_data", {bus_addr2, bus_wdata2}, {16'hFE00 + 16'(w2), 8'(w2) ^ 8'h5A});
            w2++;
        end
        if (dma_done2) done2++;
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        step();
        reg_wr    = 1'b0;
    endtask

    task automatic readback(input string tag, input logic [7:0] exp);
        reg_addr = 16'hFF46;
        reg_rd   = 1'b1;
        step();
        reg_rd   = 1'b0;
        check(tag, {reg_rdata_oe, reg_rdata}, {1'b1, exp});
        step();
        check("readback_oe_drops", reg_rdata_oe, 0);
    endtask

    task automatic wait_rd(input logic [15:0] a, input int budget);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            step();
            if (seen_rd && seen_rd_addr == a) found = 1'b1;
        end
        check("wait_rd_reached", found, 1);
    endtask

    task automatic wait_done(input int budget);
        int c0;
        c0 = done_count;
        for (int n = 0; n < budget && done_count == c0; n++) step();
        check("wait_done_reached", done_count, c0 + 1);
    endtask

    initial begin
        step();
        step();
        check("reset_bus_outs", {bus_req, dma_busy, bus_rd, bus_wr, bus_wdata_oe, dma_done}, 0);
        check("reset_addr_data", {bus_addr, bus_wdata, reg_rdata, reg_rdata_oe}, 0);
        reset = 1'b0;
        step();

        // Full transfer from C1 with grant held
        push_transfer(8'hC1, 0, 159);
        first_rd = -1;
        reg_write(16'hFF46, 8'hC1);
        start_cyc = cyc;
        check("start_busy_req", {dma_busy, bus_req}, 2'b11);
        wait_done(600);
        check("first_rd_latency", first_rd - start_cyc, 2);
        check("duration_480", done_cyc - first_rd, 480);
        check("queues_empty_1", exp_rd.size() + exp_wr.size(), 0);
        check("idle_after_done", {dma_busy, bus_req}, 0);
        readback("readback_c1", 8'hC1);

        // Accesses to a neighbouring address are ignored
        reg_addr = 16'hFF47;
        reg_rd   = 1'b1;
        step();
        reg_rd   = 1'b0;
        check("other_addr_no_oe", reg_rdata_oe, 0);
        reg_write(16'hFF47, 8'h33);
        check("other_addr_no_start", dma_busy, 0);

        // Grant dropped for 5 cycles in byte 10's write phase
        push_transfer(8'hC1, 0, 159);
        first_rd = -1;
        reg_write(16'hFF46, 8'hC1);
        wait_rd(16'hC10A, 100);
        step();
        bus_grant = 1'b0;
        repeat (5) step();
        check("req_held_without_grant", bus_req, 1);
        bus_grant = 1'b1;
        wait_done(600);
        check("duration_485", done_cyc - first_rd, 485);
        check("queues_empty_2", exp_rd.size() + exp_wr.size(), 0);

        // Register write while busy at byte 50
        push_transfer(8'hC1, 0, 159);
        reg_write(16'hFF46, 8'hC1);
        wait_rd(16'hC132, 300);
        reg_write(16'hFF46, 8'hD0);
`ifdef OAM_DMA_RESTART_EN
        exp_rd.delete();
        exp_wr.delete();
        push_transfer(8'hD0, 0, 159);
        readback("readback_busy_restart", 8'hD0);
`else
        readback("readback_busy_ignored", 8'hC1);
`endif
        wait_done(700);
        repeat (3) step();
        check("queues_empty_3", exp_rd.size() + exp_wr.size(), 0);

        // Reset at byte 80, then a fresh transfer from page 80
        push_transfer(8'hC1, 0, 159);
        reg_write(16'hFF46, 8'hC1);
        wait_rd(16'hC150, 400);
        reset = 1'b1;
        #1;
        check("reset_mid_outs", {bus_req, dma_busy, bus_rd, bus_wr, bus_wdata_oe, dma_done}, 0);
        check("reset_mid_addr", {bus_addr, bus_wdata}, 0);
        start_cyc = done_count;
        repeat (3) step();
        check("reset_no_done", done_count, start_cyc);
        exp_rd.delete();
        exp_wr.delete();
        reset = 1'b0;
        step();
        push_transfer(8'h80, 0, 159);
        first_rd = -1;
        reg_write(16'hFF46, 8'h80);
        wait_done(600);
        check("duration_after_reset", done_cyc - first_rd, 480);
        check("queues_empty_4", exp_rd.size() + exp_wr.size(), 0);
        readback("readback_80", 8'h80);

        // 256-byte instance from page FF: source index wraps without touching src_hi
        reg_addr  = 16'hFF46;
        reg_wdata = 8'hFF;
        reg_wr2   = 1'b1;
        step();
        reg_wr2   = 1'b0;
        for (int n = 0; n < 900 && done2 == 0; n++) step();
        check("dut256_done", done2, 1);
        check("dut256_reads", r2, 256);
        check("dut256_writes", w2, 256);
        check("dut256_idle", {dma_busy2, bus_req2}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/oam_dma_master.md
Name: oam_dma_master

Overview:
- Bus initiator that performs the OAM DMA transfer into the graphics peripheral's OAM window.
- A CPU write to the DMA register starts the transfer. The block requests the bus, then copies OAM_BYTES bytes from {src_hi, 8'h00} upward to OAM_BASE upward.
- Each byte uses one read transaction followed by one write transaction on the shared data bus.
- On the register side it acts as a responder; on the transfer side it is the initiator that the graphics block responds to.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU-visible start/source register address.
- OAM_BASE, 16'hFE00, first destination address.
- OAM_BYTES, 160, bytes per transfer (1..256).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- reg_addr  in  16  CPU bus address (register decode).
- reg_wr  in  1  CPU write strobe.
- reg_rd  in  1  CPU read strobe.
- reg_wdata  in  8  CPU write data.
- reg_rdata  out  8  register readback data.
- reg_rdata_oe  out  1  readback valid / drive enable.
- bus_req  out  1  request bus ownership (CPU hold).
- bus_grant  in  1  arbiter grant.
- bus_addr  out  16  initiator address.
- bus_rd  out  1  initiator read strobe.
- bus_wr  out  1  initiator write strobe.
- bus_wdata  out  8  initiator write data.
- bus_wdata_oe  out  1  drive enable for bus_wdata.
- bus_rdata  in  8  responder data; valid the cycle after bus_rd.
- dma_busy  out  1  high from the start edge until done.
- dma_done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (async): FSM=IDLE, src_hi=0, index=0, data_latch=0. All outputs 0.
- Register read: reg_rd && reg_addr==DMA_REG_ADDR → next cycle reg_rdata=src_hi and reg_rdata_oe=1. Otherwise reg_rdata_oe=0.
- Start: reg_wr && reg_addr==DMA_REG_ADDR in IDLE → src_hi<=reg_wdata, index<=0, FSM→REQ. dma_busy and bus_req are high from the next cycle.
- FSM states:
  - IDLE: no bus activity.
  - REQ: bus_req=1; when bus_grant=1 at an edge → RD.
  - RD: bus_addr={src_hi,index}, bus_rd=1 for one cycle → CAP.
  - CAP: data_latch<=bus_rdata → WR.
  - WR: bus_addr=OAM_BASE+index, bus_wr=1, bus_wdata=data_latch, bus_wdata_oe=1 for one cycle. If index==OAM_BYTES-1 → DONE; else index++ → RD.
  - DONE: dma_done=1 for one cycle; bus_req and dma_busy drop in that same cycle; → IDLE.
- Timing with grant held: 3 cycles per byte. If the first bus_rd is in cycle k, byte i reads in k+3i and writes in k+3i+2; dma_done is in k+3·OAM_BYTES.
- Grant loss: bus_rd and bus_wr are gated by bus_grant. In RD or WR with bus_grant=0 the FSM stalls and reissues the same phase once grant returns. CAP completes regardless, because the data was already returned. bus_req stays high throughout.
- Width/arithmetic:
  - index is 8 bits; source address is the concatenation {src_hi,index}, with no carry into src_hi.
  - Destination sum is 16-bit and wraps modulo 2^16.
- Any src_hi value is accepted, including 8'hFE (self-copy).
- Register writes while busy: ignored. src_hi is unchanged and readback still returns the active source (subject to the feature below).
- Writes to other addresses: ignored.
- Reset mid-transfer: immediate IDLE, bus released, no dma_done pulse.

Optional Feature:
- Macro: OAM_DMA_RESTART_EN.
- Defined: a DMA register write while busy loads the new src_hi and sets index<=0. The FSM goes to RD if currently granted, else REQ. Any in-flight byte is abandoned; a write strobe in that same cycle still completes. No dma_done is issued for the aborted transfer.
- Undefined: writes while busy are ignored, as above.

Decomposition:
- Add to a shared package (video_types or a dma_types package):
  - DMA_REG_ADDR, OAM_BASE, OAM_BYTES defaults.
  - enum dma_state_t {IDLE, REQ, RD, CAP, WR, DONE}.
- The register-decode/readback logic is natural as a sub-module, dma_reg_if (address match, src_hi register, readback). The FSM and datapath stay in oam_dma_master.

Test Plan:
- Write 8'hC1 to FF46 with grant tied high → 160 reads C100..C19F, 160 writes FE00..FE9F with matching data. Each byte takes 3 cycles; dma_done falls 480 cycles after the first bus_rd, and bus_req drops with it.
- Responder returns data = addr[7:0]^8'h5A → OAM byte i equals i^8'h5A; read FF46 → 8'hC1 with reg_rdata_oe one cycle later.
- Drop bus_grant for 5 cycles during byte 10's WR phase → no bus_wr while low. The write reissues once with the same address FE0A and data; total duration is +5 cycles.
- Write 8'hD0 to FF46 at byte 50 → undefined macro: transfer continues from C1xx, readback 8'hC1. Defined macro: next read at D000, single dma_done after D09F.
- Assert reset at byte 80 → all outputs 0 the same cycle with no dma_done. A new write of 8'h80 then runs a full transfer from 8000.
- OAM_BYTES=256 with src_hi 8'hFF → source wraps FF00..FFFF without touching src_hi; destination covers FE00..FEFF.
